// File: rtl/qspi_xfer_arbiter.sv
// ---------------------------------------------------------------------------
// qspi_xfer_arbiter
//
// Arbitrates between an XIP read requester and an indirect (register driven)
// requester for a single QSPI datapath, then sequences the granted transfer
// through CMD -> ADDR -> DUMMY -> DATA -> DONE. Phase lengths are counted in
// SCLK shift edges (sclk_tick_in); with no ticks the sequencer holds.
//
// Configuration macro:
//   QSPI_ARB_RR_EN  defined   : round-robin on simultaneous requests; the
//                               requester not granted last wins; the
//                               priority pointer moves at DONE.
//                   undefined : fixed priority, XIP wins simultaneous requests.
//
// Ports:
//   h_clk, h_rst          clock, asynchronous active-high reset
//   sclk_tick_in          one-cycle pulse per SCLK shift edge
//   lines_in              00 single, 01 dual, 10 quad, 11 single
//   addr_4b_in            1: 32-bit address, 0: 24-bit address
//   dummy_cycles_in       dummy SCLK count (0 skips DUMMY)
//   xip_*                 XIP requester: req, addr, beats (1..16), grant
//   ind_*                 indirect requester: req, cmd, addr enable, addr,
//                         byte count, grant
//   load_cmd_out/cmd_out  command shift-register load pulse and value
//   load_addr_out/addr_out address shift-register load pulse and value
//   phase_out             0 IDLE, 1 CMD, 2 ADDR, 3 DUMMY, 4 DATA, 5 DONE
//   shift_en_out          high in CMD and ADDR
//   sample_en_out         high in DATA
//   beat_done_out         pulse on the last tick of every 32-bit beat
//   done_out              pulse for the single DONE cycle
//   busy_out              high whenever phase_out != IDLE
// ---------------------------------------------------------------------------
module qspi_xfer_arbiter (
    input  logic        h_clk,
    input  logic        h_rst,
    input  logic        sclk_tick_in,
    input  logic [1:0]  lines_in,
    input  logic        addr_4b_in,
    input  logic [3:0]  dummy_cycles_in,
    input  logic        xip_req_in,
    input  logic [31:0] xip_addr_in,
    input  logic [4:0]  xip_beats_in,
    output logic        xip_grant_out,
    input  logic        ind_req_in,
    input  logic [7:0]  ind_cmd_in,
    input  logic        ind_addr_en_in,
    input  logic [31:0] ind_addr_in,
    input  logic [7:0]  ind_bytes_in,
    output logic        ind_grant_out,
    output logic        load_cmd_out,
    output logic [7:0]  cmd_out,
    output logic        load_addr_out,
    output logic [31:0] addr_out,
    output logic [2:0]  phase_out,
    output logic        shift_en_out,
    output logic        sample_en_out,
    output logic        beat_done_out,
    output logic        done_out,
    output logic        busy_out
);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_CMD   = 3'd1,
        PH_ADDR  = 3'd2,
        PH_DUMMY = 3'd3,
        PH_DATA  = 3'd4,
        PH_DONE  = 3'd5
    } phase_t;

    // Lane code 11 behaves as single lane everywhere downstream.
    function automatic logic [1:0] norm_lines(input logic [1:0] l);
        return (l == 2'b11) ? 2'b00 : l;
    endfunction

    function automatic logic [7:0] xip_cmd(input logic [1:0] l, input logic a4);
        if (l == 2'b10) begin
            return a4 ? 8'hEC : 8'hEB;
        end else begin
            return a4 ? 8'h13 : 8'h03;
        end
    endfunction

    // Byte count rounded up to 32-bit beats; 9-bit sum so 8'hFF does not wrap.
    function automatic logic [6:0] ind_beats(input logic [7:0] b);
        return 7'(({1'b0, b} + 9'd3) >> 2);
    endfunction

    function automatic logic [5:0] addr_len(input logic [1:0] l, input logic a4);
        case (l)
            2'b01:   return a4 ? 6'd16 : 6'd12;
            2'b10:   return a4 ? 6'd8  : 6'd6;
            default: return a4 ? 6'd32 : 6'd24;
        endcase
    endfunction

    function automatic logic [5:0] beat_len(input logic [1:0] l);
        case (l)
            2'b01:   return 6'd16;
            2'b10:   return 6'd8;
            default: return 6'd32;
        endcase
    endfunction

    // {shift_en, sample_en, done, busy} as seen while sitting in phase p.
    function automatic logic [3:0] phase_flags(input phase_t p);
        return {(p == PH_CMD) || (p == PH_ADDR), p == PH_DATA, p == PH_DONE, p != PH_IDLE};
    endfunction

    phase_t      r_phase;
    logic        r_xip_grant;
    logic        r_ind_grant;
    logic        r_load_cmd;
    logic        r_load_addr;
    logic [7:0]  r_cmd;
    logic [31:0] r_addr;
    logic [1:0]  r_lines;
    logic        r_addr_4b;
    logic [3:0]  r_dummy;
    logic [6:0]  r_beats;
    logic        r_has_addr;
    logic [5:0]  r_cnt;
    logic [6:0]  r_beat_cnt;
    logic        r_shift_en;
    logic        r_sample_en;
    logic        r_beat_done;
    logic        r_done;
    logic        r_busy;

    logic [1:0]  w_lines;
    logic        w_pick_xip;
    logic        w_pick_ind;
    logic [5:0]  w_addr_last;
    logic [5:0]  w_beat_last;
    logic [5:0]  w_dummy_last;
    phase_t      w_after_dummy;
    phase_t      w_after_addr;
    phase_t      w_after_cmd;

    assign w_lines      = norm_lines(lines_in);
    assign w_addr_last  = addr_len(r_lines, r_addr_4b) - 6'd1;
    assign w_beat_last  = beat_len(r_lines) - 6'd1;
    assign w_dummy_last = {2'b00, r_dummy} - 6'd1;

    // Phases with a zero length are skipped by chaining to the next one.
    assign w_after_dummy = (r_beats != 7'd0) ? PH_DATA : PH_DONE;
    assign w_after_addr  = (r_dummy != 4'd0) ? PH_DUMMY : w_after_dummy;
    assign w_after_cmd   = r_has_addr ? PH_ADDR : w_after_addr;

`ifdef QSPI_ARB_RR_EN
    logic r_prio_ind;
    assign w_pick_xip = xip_req_in & (~ind_req_in | ~r_prio_ind);
`else
    assign w_pick_xip = xip_req_in;
`endif
    assign w_pick_ind = ind_req_in & ~w_pick_xip;

    // Arbitration and transfer sequencer.
    always_ff @(posedge h_clk or posedge h_rst) begin
        if (h_rst) begin
            r_phase     <= PH_IDLE;
            r_xip_grant <= 1'b0;
            r_ind_grant <= 1'b0;
            r_load_cmd  <= 1'b0;
            r_load_addr <= 1'b0;
            r_cmd       <= 8'd0;
            r_addr      <= 32'd0;
            r_lines     <= 2'd0;
            r_addr_4b   <= 1'b0;
            r_dummy     <= 4'd0;
            r_beats     <= 7'd0;
            r_has_addr  <= 1'b0;
            r_cnt       <= 6'd0;
            r_beat_cnt  <= 7'd0;
            r_shift_en  <= 1'b0;
            r_sample_en <= 1'b0;
            r_beat_done <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef QSPI_ARB_RR_EN
            r_prio_ind  <= 1'b0;
`endif
        end else begin
            r_load_cmd  <= 1'b0;
            r_load_addr <= 1'b0;
            r_beat_done <= 1'b0;
            case (r_phase)
                PH_IDLE: begin
                    if (w_pick_xip || w_pick_ind) begin
                        r_xip_grant <= w_pick_xip;
                        r_ind_grant <= w_pick_ind;
                        r_cmd       <= w_pick_xip ? xip_cmd(w_lines, addr_4b_in) : ind_cmd_in;
                        r_addr      <= w_pick_xip ? xip_addr_in : ind_addr_in;
                        r_beats     <= w_pick_xip ? {2'b00, xip_beats_in} : ind_beats(ind_bytes_in);
                        r_has_addr  <= w_pick_xip | ind_addr_en_in;
                        r_lines     <= w_lines;
                        r_addr_4b   <= addr_4b_in;
                        r_dummy     <= dummy_cycles_in;
                        r_cnt       <= 6'd0;
                        r_beat_cnt  <= 7'd0;
                        r_load_cmd  <= 1'b1;
                        r_phase     <= PH_CMD;
                        {r_shift_en, r_sample_en, r_done, r_busy} <= phase_flags(PH_CMD);
                    end else begin
                        r_xip_grant <= 1'b0;
                        r_ind_grant <= 1'b0;
                    end
                end
                PH_CMD: begin
                    if (sclk_tick_in) begin
                        if (r_cnt == 6'd7) begin
                            r_cnt       <= 6'd0;
                            r_load_addr <= (w_after_cmd == PH_ADDR);
                            r_phase     <= w_after_cmd;
                            {r_shift_en, r_sample_en, r_done, r_busy} <= phase_flags(w_after_cmd);
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                PH_ADDR: begin
                    if (sclk_tick_in) begin
                        if (r_cnt == w_addr_last) begin
                            r_cnt   <= 6'd0;
                            r_phase <= w_after_addr;
                            {r_shift_en, r_sample_en, r_done, r_busy} <= phase_flags(w_after_addr);
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                PH_DUMMY: begin
                    if (sclk_tick_in) begin
                        if (r_cnt == w_dummy_last) begin
                            r_cnt   <= 6'd0;
                            r_phase <= w_after_dummy;
                            {r_shift_en, r_sample_en, r_done, r_busy} <= phase_flags(w_after_dummy);
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                PH_DATA: begin
                    if (sclk_tick_in) begin
                        if (r_cnt == w_beat_last) begin
                            r_cnt       <= 6'd0;
                            r_beat_done <= 1'b1;
                            if (r_beat_cnt == (r_beats - 7'd1)) begin
                                r_beat_cnt <= 7'd0;
                                r_phase    <= PH_DONE;
                                {r_shift_en, r_sample_en, r_done, r_busy} <= phase_flags(PH_DONE);
                            end else begin
                                r_beat_cnt <= r_beat_cnt + 7'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                PH_DONE: begin
                    // Grant is held through DONE and released here.
                    r_xip_grant <= 1'b0;
                    r_ind_grant <= 1'b0;
                    r_phase     <= PH_IDLE;
                    {r_shift_en, r_sample_en, r_done, r_busy} <= phase_flags(PH_IDLE);
`ifdef QSPI_ARB_RR_EN
                    r_prio_ind  <= r_xip_grant;
`endif
                end
                default: begin
                    r_xip_grant <= 1'b0;
                    r_ind_grant <= 1'b0;
                    r_phase     <= PH_IDLE;
                    {r_shift_en, r_sample_en, r_done, r_busy} <= phase_flags(PH_IDLE);
                end
            endcase
        end
    end

    assign xip_grant_out = r_xip_grant;
    assign ind_grant_out = r_ind_grant;
    assign load_cmd_out  = r_load_cmd;
    assign cmd_out       = r_cmd;
    assign load_addr_out = r_load_addr;
    assign addr_out      = r_addr;
    assign phase_out     = r_phase;
    assign shift_en_out  = r_shift_en;
    assign sample_en_out = r_sample_en;
    assign beat_done_out = r_beat_done;
    assign done_out      = r_done;
    assign busy_out      = r_busy;

endmodule

// File: tb/tb_qspi_xfer_arbiter.sv
// Scoreboard bench for qspi_xfer_arbiter: the stimulus process pushes the
// expected transfer (from a transaction-level model) when requests are
// evaluated; a monitor process measures each transfer and compares at done.
module tb_qspi_xfer_arbiter;

    logic        h_clk;
    logic        h_rst;
    logic        sclk_tick_in;
    logic [1:0]  lines_in;
    logic        addr_4b_in;
    logic [3:0]  dummy_cycles_in;
    logic        xip_req_in;
    logic [31:0] xip_addr_in;
    logic [4:0]  xip_beats_in;
    logic        xip_grant_out;
    logic        ind_req_in;
    logic [7:0]  ind_cmd_in;
    logic        ind_addr_en_in;
    logic [31:0] ind_addr_in;
    logic [7:0]  ind_bytes_in;
    logic        ind_grant_out;
    logic        load_cmd_out;
    logic [7:0]  cmd_out;
    logic        load_addr_out;
    logic [31:0] addr_out;
    logic [2:0]  phase_out;
    logic        shift_en_out;
    logic        sample_en_out;
    logic        beat_done_out;
    logic        done_out;
    logic        busy_out;

    qspi_xfer_arbiter dut (
        .h_clk(h_clk), .h_rst(h_rst), .sclk_tick_in(sclk_tick_in),
        .lines_in(lines_in), .addr_4b_in(addr_4b_in), .dummy_cycles_in(dummy_cycles_in),
        .xip_req_in(xip_req_in), .xip_addr_in(xip_addr_in), .xip_beats_in(xip_beats_in),
        .xip_grant_out(xip_grant_out),
        .ind_req_in(ind_req_in), .ind_cmd_in(ind_cmd_in), .ind_addr_en_in(ind_addr_en_in),
        .ind_addr_in(ind_addr_in), .ind_bytes_in(ind_bytes_in), .ind_grant_out(ind_grant_out),
        .load_cmd_out(load_cmd_out), .cmd_out(cmd_out), .load_addr_out(load_addr_out),
        .addr_out(addr_out), .phase_out(phase_out), .shift_en_out(shift_en_out),
        .sample_en_out(sample_en_out), .beat_done_out(beat_done_out), .done_out(done_out),
        .busy_out(busy_out)
    );

    typedef struct {
        bit          ind;
        logic [7:0]  cmd;
        logic [31:0] addr;
        bit          has_addr;
        int          addr_t;
        int          dummy_t;
        int          beats;
        int          beat_t;
    } exp_t;

    exp_t sb_q[$];
    bit   m_prio_ind;
    int   n_total;
    int   n_bad;
    int   viol;

    initial begin
        h_clk = 1'b0;
        forever #5 h_clk = ~h_clk;
    end

    initial begin
        sclk_tick_in = 1'b0;
        forever begin
            @(posedge h_clk);
            #1;
            sclk_tick_in = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    endtask

    function automatic logic [51:0] all_outs();
        return {xip_grant_out, ind_grant_out, load_cmd_out, cmd_out, load_addr_out, addr_out,
                phase_out, shift_en_out, sample_en_out, beat_done_out, done_out, busy_out};
    endfunction

    // Reference model: expected transfer for the requester granted now.
    task automatic push_expect(input bit w_ind);
        exp_t e;
        int   lanes;
        lanes = (lines_in == 2'd2) ? 4 : ((lines_in == 2'd1) ? 2 : 1);
        e.ind = w_ind;
        if (!w_ind) begin
            e.cmd      = (lanes == 4) ? (addr_4b_in ? 8'hEC : 8'hEB) : (addr_4b_in ? 8'h13 : 8'h03);
            e.addr     = xip_addr_in;
            e.has_addr = 1'b1;
            e.beats    = int'(xip_beats_in);
        end else begin
            e.cmd      = ind_cmd_in;
            e.addr     = ind_addr_in;
            e.has_addr = ind_addr_en_in;
            e.beats    = (int'(ind_bytes_in) + 3) / 4;
        end
        e.addr_t  = e.has_addr ? ((addr_4b_in ? 32 : 24) / lanes) : 0;
        e.dummy_t = int'(dummy_cycles_in);
        e.beat_t  = 32 / lanes;
        sb_q.push_back(e);
        m_prio_ind = !w_ind;
    endtask

    function automatic bit pick_ind();
        if (xip_req_in && ind_req_in) begin
`ifdef QSPI_ARB_RR_EN
            return m_prio_ind;
`else
            return 1'b0;
`endif
        end
        return !xip_req_in;
    endfunction

    // Monitor: measures each transfer from load_cmd to done and scores it.
    initial begin : monitor
        bit          act;
        bit          saw_addr;
        bit          cap_x;
        bit          cap_i;
        logic [7:0]  cap_cmd;
        logic [31:0] cap_addr;
        int          t_cmd, t_addr, t_dummy, t_data, n_beat;
        logic [2:0]  prev_phase;
        exp_t        e;
        act = 1'b0; saw_addr = 1'b0; cap_x = 1'b0; cap_i = 1'b0;
        cap_cmd = 8'd0; cap_addr = 32'd0; prev_phase = 3'd0;
        t_cmd = 0; t_addr = 0; t_dummy = 0; t_data = 0; n_beat = 0; viol = 0;
        forever begin
            @(negedge h_clk);
            if (h_rst) begin
                act = 1'b0;
                prev_phase = 3'd0;
                viol = 0;
            end else begin
                if (load_cmd_out) begin
                    check("idle_gap", prev_phase, 3'd0);
                    act = 1'b1; saw_addr = 1'b0;
                    cap_x = xip_grant_out; cap_i = ind_grant_out; cap_cmd = cmd_out;
                    cap_addr = 32'd0;
                    t_cmd = 0; t_addr = 0; t_dummy = 0; t_data = 0; n_beat = 0;
                end
                if (load_addr_out) begin
                    cap_addr = addr_out;
                    saw_addr = 1'b1;
                end
                if (act && sclk_tick_in) begin
                    case (phase_out)
                        3'd1:    t_cmd++;
                        3'd2:    t_addr++;
                        3'd3:    t_dummy++;
                        3'd4:    t_data++;
                        default: ;
                    endcase
                end
                if (beat_done_out) n_beat++;
                if (busy_out != (phase_out != 3'd0)) viol++;
                if (shift_en_out != ((phase_out == 3'd1) || (phase_out == 3'd2))) viol++;
                if (sample_en_out != (phase_out == 3'd4)) viol++;
                if ((phase_out != 3'd0) != (xip_grant_out ^ ind_grant_out)) viol++;
                if (act && ((xip_grant_out != cap_x) || (ind_grant_out != cap_i))) viol++;
                if (done_out) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1'b1, 1'b0);
                    end else begin
                        e = sb_q.pop_front();
                        check("owner", {cap_x, cap_i}, {!e.ind, e.ind});
                        check("cmd", cap_cmd, e.cmd);
                        check("addr_load", saw_addr, e.has_addr);
                        if (e.has_addr) check("addr", cap_addr, e.addr);
                        check("cmd_ticks", t_cmd, 8);
                        check("addr_ticks", t_addr, e.addr_t);
                        check("dummy_ticks", t_dummy, e.dummy_t);
                        check("data_ticks", t_data, e.beats * e.beat_t);
                        check("beat_pulses", n_beat, e.beats);
                        check("done_phase", phase_out, 3'd5);
                        check("signal_rules", viol, 0);
                        check("started", act, 1'b1);
                    end
                    act = 1'b0;
                    viol = 0;
                end
                prev_phase = phase_out;
            end
        end
    end

    task automatic rand_shared();
        lines_in        = 2'($urandom_range(0, 3));
        addr_4b_in      = 1'($urandom_range(0, 1));
        dummy_cycles_in = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    endtask

    task automatic rand_xip();
        xip_addr_in  = $urandom;
        xip_beats_in = 5'($urandom_range(1, 16));
    endtask

    task automatic rand_ind();
        ind_cmd_in     = 8'($urandom);
        ind_addr_en_in = 1'($urandom_range(0, 1));
        ind_addr_in    = $urandom;
        ind_bytes_in   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 100));
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 50; i++) begin
            @(negedge h_clk);
            if (xip_grant_out || ind_grant_out) begin
                check("grant_load_cmd", {load_cmd_out, phase_out}, {1'b1, 3'd1});
                return;
            end
        end
        check("grant_timeout", 1'b1, 1'b0);
        finish_run();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 8000; i++) begin
            @(negedge h_clk);
            if (done_out) return;
        end
        check("done_timeout", 1'b1, 1'b0);
        finish_run();
    endtask

    // Raise requests, then serve until nobody is requesting; the loser of a
    // tie keeps its request (and its own parameters) until granted.
    task automatic serve(input bit rx, input bit ri, input int force_re, input bit rand_re);
        bit w;
        int chain;
        chain = 0;
        if (rx) xip_req_in = 1'b1;
        if (ri) ind_req_in = 1'b1;
        while (xip_req_in || ind_req_in) begin
            chain++;
            w = pick_ind();
            push_expect(w);
            wait_grant();
            if (w) ind_req_in = 1'b0; else xip_req_in = 1'b0;
            // Inputs change under an active transfer; the transfer must not see it.
            rand_shared();
            if (w) rand_ind(); else rand_xip();
            wait_done();
            rand_shared();
            if ((xip_req_in || ind_req_in) && chain < 5 &&
                (force_re > 0 || (rand_re && $urandom_range(0, 1) == 1))) begin
                force_re--;
                if (w) ind_req_in = 1'b1; else xip_req_in = 1'b1;
            end
        end
    endtask

    task automatic reset_mid_addr();
        int k;
        rand_xip();
        lines_in = 2'd2; addr_4b_in = 1'b0; dummy_cycles_in = 4'd4;
        xip_req_in = 1'b1;
        push_expect(1'b0);
        wait_grant();
        xip_req_in = 1'b0;
        k = 0;
        for (int i = 0; i < 2000 && k < 3; i++) begin
            @(negedge h_clk);
            if (phase_out == 3'd2 && sclk_tick_in) k++;
        end
        check("reached_addr_tick3", k, 3);
        h_rst = 1'b1;
        sb_q.delete();
        m_prio_ind = 1'b0;
        #1;
        check("reset_abort_outs", all_outs(), 52'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge h_clk);
            check("reset_hold_no_done", {done_out, all_outs()}, 53'd0);
        end
        h_rst = 1'b0;
        rand_shared();
        rand_xip();
        serve(1'b1, 1'b0, 0, 1'b0);
    endtask

    initial begin : watchdog
        #900000;
        check("watchdog", 1'b1, 1'b0);
        finish_run();
    end

    initial begin : stim
        n_total = 0; n_bad = 0; m_prio_ind = 1'b0;
        h_rst = 1'b1;
        xip_req_in = 1'b0; ind_req_in = 1'b0;
        lines_in = 2'd0; addr_4b_in = 1'b0; dummy_cycles_in = 4'd0;
        xip_addr_in = 32'd0; xip_beats_in = 5'd1;
        ind_cmd_in = 8'd0; ind_addr_en_in = 1'b0; ind_addr_in = 32'd0; ind_bytes_in = 8'd0;
        repeat (3) @(negedge h_clk);
        check("reset_outs", all_outs(), 52'd0);
        h_rst = 1'b0;
        repeat (2) @(negedge h_clk);

        // Tie right after reset, then a second tie against the held loser.
        rand_shared(); rand_xip(); rand_ind();
        serve(1'b1, 1'b1, 1, 1'b0);

        // XIP quad 24-bit, 4 dummy, one beat.
        rand_xip();
        lines_in = 2'd2; addr_4b_in = 1'b0; dummy_cycles_in = 4'd4; xip_beats_in = 5'd1;
        serve(1'b1, 1'b0, 0, 1'b0);

        // Indirect 9F, no address, 5 bytes, single lane.
        lines_in = 2'd0; addr_4b_in = 1'b0; dummy_cycles_in = 4'd0;
        ind_cmd_in = 8'h9F; ind_addr_en_in = 1'b0; ind_addr_in = $urandom; ind_bytes_in = 8'd5;
        serve(1'b0, 1'b1, 0, 1'b0);

        // Indirect zero bytes, 32-bit dual address, no dummy.
        lines_in = 2'd1; addr_4b_in = 1'b1; dummy_cycles_in = 4'd0;
        ind_cmd_in = 8'h5A; ind_addr_en_in = 1'b1; ind_addr_in = $urandom; ind_bytes_in = 8'd0;
        serve(1'b0, 1'b1, 0, 1'b0);

        // Lane code 11 behaves as single lane; 255 bytes -> 64 beats.
        lines_in = 2'd3; addr_4b_in = 1'b1; dummy_cycles_in = 4'd15;
        ind_cmd_in = 8'hA5; ind_addr_en_in = 1'b1; ind_addr_in = $urandom; ind_bytes_in = 8'd255;
        serve(1'b0, 1'b1, 0, 1'b0);

        reset_mid_addr();

        for (int r = 0; r < 25; r++) begin
            bit rx;
            bit ri;
            rx = 1'($urandom_range(0, 1));
            ri = rx ? 1'($urandom_range(0, 1)) : 1'b1;
            rand_shared(); rand_xip(); rand_ind();
            serve(rx, ri, 0, 1'b1);
            repeat ($urandom_range(1, 4)) @(negedge h_clk);
        end

        repeat (3) @(negedge h_clk);
        check("scoreboard_drained", sb_q.size(), 0);
        check("idle_signal_rules", viol, 0);
        finish_run();
    end

endmodule

// File: doc/qspi_xfer_arbiter.md
QSPI_XFER_ARBITER -- requirements
Module: qspi_xfer_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 h_clk  in  1  system clock; all state on posedge.
REQ-003 h_rst  in  1  asynchronous active-high reset.
REQ-004 sclk_tick_in  in  1  one-h_clk pulse per SCLK shift edge from the datapath clock generator.
REQ-005 lines_in  in  2  00 single, 01 dual, 10 quad, 11 treated as single; addr_4b_in  in  1  32-bit address when 1, else 24-bit; dummy_cycles_in  in  4  dummy SCLK count.
REQ-006 xip_req_in  in  1 / xip_addr_in  in  32 / xip_beats_in  in  5 (1..16) / xip_grant_out  out  1  XIP read requester.
REQ-007 ind_req_in  in  1 / ind_cmd_in  in  8 / ind_addr_en_in  in  1 / ind_addr_in  in  32 / ind_bytes_in  in  8 / ind_grant_out  out  1  indirect requester.
REQ-008 load_cmd_out  out  1, cmd_out  out  8, load_addr_out  out  1, addr_out  out  32  datapath shift-register loads.
REQ-009 phase_out  out  3  0 IDLE, 1 CMD, 2 ADDR, 3 DUMMY, 4 DATA, 5 DONE; shift_en_out  out  1; sample_en_out  out  1.
REQ-010 beat_done_out  out  1, done_out  out  1  single-cycle pulses; busy_out  out  1  high whenever phase_out != IDLE.

Function
REQ-011 Requests SHALL be evaluated only in IDLE; a requester holds req until its grant; grants are one-hot and held from grant cycle through DONE.
REQ-012 On grant, cmd, addr, lines, addr_4b, dummy count and beat count SHALL be registered; later input changes SHALL not affect the transfer.
REQ-013 XIP cmd_out: quad -> 8'hEB (24b) / 8'hEC (32b); otherwise 8'h03 (24b) / 8'h13 (32b); indirect cmd_out = ind_cmd_in.
REQ-014 Indirect beats = (ind_bytes_in + 3) >> 2 in 9-bit arithmetic; ind_bytes_in = 0 SHALL skip DATA.
REQ-015 Grant cycle: load_cmd_out pulses one cycle, phase -> CMD.
REQ-016 CMD: shift_en_out=1; exactly 8 ticks; on 8th tick go ADDR (XIP, or indirect with ind_addr_en_in=1) pulsing load_addr_out that cycle, else next enabled phase.
REQ-017 ADDR length in ticks = addr bits / lines: 24,12,6 (24b) or 32,16,8 (32b) for single, dual, quad.
REQ-018 DUMMY: shift_en_out=0; exactly dummy count ticks; count 0 SHALL skip DUMMY.
REQ-019 DATA: sample_en_out=1; each beat = 32/lines ticks (32,16,8); beat_done_out pulses on each beat's last tick; after last beat -> DONE.
REQ-020 DONE: done_out pulses one cycle, grant drops next cycle, phase -> IDLE; at least one IDLE cycle SHALL precede any new grant.
REQ-021 Phase counters advance only on sclk_tick_in; with no ticks the FSM SHALL hold.
REQ-022 Request withdrawn after grant SHALL be ignored; the transfer completes.

Reset
REQ-023 While h_rst is high, all outputs SHALL be 0, phase_out = IDLE, counters 0, priority pointer = XIP.
REQ-024 Reset asserted mid-transfer SHALL abort immediately with no done_out; after release, the next grant SHALL restart from CMD.

Configuration
REQ-025 Macro QSPI_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted last wins; pointer updates at DONE.
REQ-026 Macro QSPI_ARB_RR_EN undefined: fixed priority, XIP always wins simultaneous requests.

Verification
REQ-027 XIP, quad, 24b, dummy 4, beats 1 -> cmd 8'hEB; CMD 8, ADDR 6, DUMMY 4, DATA 8 ticks; one beat_done, one done.
REQ-028 Indirect cmd 8'h9F, addr_en 0, bytes 5, single -> CMD 8, no ADDR/DUMMY, DATA 2 beats x 32 ticks, done.
REQ-029 Both requests in IDLE after reset: XIP granted first; with QSPI_ARB_RR_EN indirect wins next tie; without it XIP wins again.
REQ-030 Reset pulse during ADDR tick 3 -> all outputs 0 same cycle, no done_out; re-request restarts at CMD with load_cmd_out pulse.
REQ-031 Indirect bytes 0, addr_en 1, 32b dual, dummy 0 -> CMD 8, ADDR 16, DONE with zero beat_done pulses.
